fixed_fisr_axi_slave: RTL and testbench
=======================================

Name: fixed_fisr_axi_slave

Overview:
- AXI4-Lite slave (responder) for the fixed-point fast-inverse-square-root IP; terminates the transactions issued by the AXI master VIP / PS.
- Provides four RW configuration/scratch words, one RO result word and one RO status word.
- Drives a start pulse and an operand to the FISR compute core, and captures the core's result.
- Sits between the AXI interconnect and the FISR datapath inside the IP top.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- core_start  out  1  one-cycle start pulse to the FISR core.
- core_operand  out  32  operand; equals REG1.
- core_busy  in  1  core computing.
- core_done  in  1  one-cycle pulse; core_result is valid in the same cycle.
- core_result  in  32  Q-format 1/sqrt result.

Behaviour:
- Reset: the clock and reset are decided as one clock; reset is asynchronous and active-low. Asserting S_AXI_ARESETN low immediately forces the following, with no clock needed:
  - AWREADY=0, WREADY=0, BVALID=0, BRESP=0, ARREADY=0, RVALID=0, RRESP=0, RDATA=0, core_start=0.
  - REG0..REG3=0, RESULT=0, DONE=0, latched AW and W cleared.
- Reset mid-transaction discards the transaction; after reset releases, no B or R response is ever issued for it.
- Register map (word index = ADDR[4:2]; ADDR[1:0] ignored):
  - 0x00 REG0 RW. A write whose final value has bit0=1 pulses core_start for one cycle, on the cycle after the commit. The stored value is kept, so readback equals the written value.
  - 0x04 REG1 RW, operand. 0x08 REG2 RW, scratch. 0x0C REG3 RW, scratch.
  - 0x10 RESULT RO; loaded from core_result on core_done.
  - 0x14 STATUS RO: bit0=core_busy (live), bit1=DONE (sticky); bits[31:2]=0.
  - 0x18 and 0x1C unmapped: read 0, writes ignored.
- Write channel:
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - AW and W handshakes are independent and may occur in either order or in the same cycle.
  - When both are held (or both handshake in cycle N), the write commits at the N+1 edge: byte lanes with WSTRB[k]=1 update bits [8k+7:8k]. In the same edge BVALID goes 1 with BRESP=OKAY and both latches clear.
  - BVALID holds until BREADY=1; no new AW/W is accepted while BVALID=1.
  - Writes to RO or unmapped slots: no state change, BRESP=OKAY.
- Read channel:
  - ARREADY = !RVALID. An AR handshake in cycle N gives RVALID=1 at N+1, with RDATA sampled from the register state at N and RRESP=OKAY.
  - RDATA/RRESP hold stable until RREADY; RDATA returns to 0 after the R handshake.
  - A read of STATUS clears DONE at the AR handshake edge. If core_done occurs in the same cycle, DONE ends up 1 (set wins) and the returned bit1 reflects the pre-edge value.
- Read and write channels operate concurrently; a same-cycle write commit and read of the same slot returns the old value.
- core_done with a concurrent AXI read of RESULT: the read returns the old value; RESULT updates at the same edge.
- A REG0 bit0 write while core_busy=1 still pulses core_start; the core ignores it.

Optional Feature:
- Macro FIXED_FISR_SLVERR_EN.
- Defined:
  - Writes to 0x10..0x1C return BRESP=SLVERR (2'b10).
  - Reads of 0x18/0x1C return RRESP=SLVERR with RDATA=0.
  - State is unchanged in both cases.
- Undefined: all responses are OKAY, as described above.

Test Plan:
- Sequential AXI4-Lite writes of 0x1,0x2,0x3,0x4 to 0x00..0x0C, then reads -> readback 0x1..0x4, all BRESP/RRESP=OKAY; core_start pulses once, after the 0x00 write.
- W issued 3 cycles before AW, data 0xA5A5A5A5 to 0x08 with WSTRB=4'b0101 over a prior value 0 -> REG2=0x00A500A5; BVALID rises exactly 1 cycle after the AW handshake.
- BREADY held low 5 cycles after a write -> BVALID stays 1, AWREADY/WREADY stay 0; the next write is accepted only after the B handshake.
- Write REG1=0x00010000, REG0=0x1; bench core raises busy, then done with result 0x0000FFFF -> STATUS reads 0x1 while busy, then 0x2, then 0x0 on the second read; RESULT=0x0000FFFF.
- Assert ARESETN low while RVALID=1 and RREADY=0 -> all outputs 0 immediately; no R beat after release; REG0..REG3 read 0.
- With FIXED_FISR_SLVERR_EN defined, write 0x10 and read 0x1C -> BRESP=2'b10, RRESP=2'b10, RDATA=0, RESULT unchanged; without the macro -> both responses OKAY.

Source files
------------

// File: rtl/fixed_fisr_axi_slave.sv
// AXI4-Lite register slave for the fixed-point FISR core: four RW words, RESULT, STATUS.
// Optional macro FIXED_FISR_SLVERR_EN: SLVERR on writes to 0x10..0x1C and reads of 0x18/0x1C.

module fixed_fisr_byte_merge (
  input  logic       strb,
  input  logic [7:0] wdata,
  input  logic [7:0] cur,
  output logic [7:0] merged
);
  assign merged = strb ? wdata : cur;
endmodule

module fixed_fisr_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            core_start,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   core_operand,
  input  logic                            core_busy,
  input  logic                            core_done,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   core_result
);
  localparam int NUM_LANES = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] IDX_RESULT = 3'd4;
  localparam logic [IDX_W-1:0] IDX_STATUS = 3'd5;

  typedef logic [NUM_LANES-1:0][7:0] word_t;

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx, ar_idx;
  word_t                 w_data, wr_merged;
  logic [NUM_LANES-1:0]  w_strb;
  word_t [3:0]           regs;
  logic [C_S_AXI_DATA_WIDTH-1:0] result;
  logic                  done;
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp, wr_resp;

  // Readies are gated by reset so they drop the instant reset asserts.
  assign S_AXI_AWREADY = S_AXI_ARESETN & ~aw_held & ~S_AXI_BVALID;
  assign S_AXI_WREADY  = S_AXI_ARESETN & ~w_held & ~S_AXI_BVALID;
  assign S_AXI_ARREADY = S_AXI_ARESETN & ~S_AXI_RVALID;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held & w_held;
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign core_operand = regs[1];

  fixed_fisr_byte_merge u_lane [NUM_LANES-1:0] (
    .strb  (w_strb),
    .wdata (w_data),
    .cur   (regs[aw_idx[1:0]]),
    .merged(wr_merged)
  );

`ifdef FIXED_FISR_SLVERR_EN
  assign wr_resp = aw_idx[IDX_W-1] ? RESP_SLVERR : RESP_OKAY;
`else
  assign wr_resp = RESP_OKAY;
`endif

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = regs[ar_idx[1:0]];
      IDX_RESULT:             rd_data = result;
      IDX_STATUS:             rd_data = {{(C_S_AXI_DATA_WIDTH-2){1'b0}}, done, core_busy};
      default: begin
`ifdef FIXED_FISR_SLVERR_EN
        rd_resp = RESP_SLVERR;
`else
        rd_resp = RESP_OKAY;
`endif
      end
    endcase
  end

  // Write path: AW and W latch independently; commit once both are held.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      w_data       <= '0;
      w_strb       <= '0;
      regs         <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= RESP_OKAY;
      core_start   <= 1'b0;
    end else begin
      core_start <= 1'b0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_resp;
        if (!aw_idx[IDX_W-1]) begin
          regs[aw_idx[1:0]] <= wr_merged;
          if (aw_idx == '0 && wr_merged[0][0]) core_start <= 1'b1;
        end
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Read path plus core capture; a core_done in the same cycle as a STATUS read wins.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= RESP_OKAY;
      result       <= '0;
      done         <= 1'b0;
    end else begin
      if (ar_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_resp;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
        S_AXI_RDATA  <= '0;
        S_AXI_RRESP  <= RESP_OKAY;
      end
      if (core_done) begin
        result <= core_result;
        done   <= 1'b1;
      end else if (ar_hs && ar_idx == IDX_STATUS) begin
        done <= 1'b0;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_fixed_fisr_axi_slave.sv
// Directed bench for fixed_fisr_axi_slave; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_fixed_fisr_axi_slave;
  logic        clk = 0, rst_n = 0;
  logic [4:0]  awaddr = 0, araddr = 0;
  logic [2:0]  awprot = 0, arprot = 0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        core_start, core_busy = 0, core_done = 0;
  logic [31:0] core_operand, core_result = 0;

  int vectors = 0, errors = 0, start_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (core_start) start_cnt++;

  fixed_fisr_axi_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_start(core_start), .core_operand(core_operand), .core_busy(core_busy),
    .core_done(core_done), .core_result(core_result)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string what);
    vectors++; errors++;
    $display("FAIL %s: handshake timeout", what);
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    logic ar_ok, w_ok;
    bit got;
    resp = 2'bxx; got = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && (awvalid || wvalid); i++) begin
      ar_ok = awready; w_ok = wready;
      tick();
      if (ar_ok) awvalid = 0;
      if (w_ok) wvalid = 0;
    end
    if (awvalid || wvalid) begin awvalid = 0; wvalid = 0; timeout("aw/w"); end
    bready = 1;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin resp = bresp; got = 1; tick(); break; end
      tick();
    end
    bready = 0;
    if (!got) timeout("b");
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit got;
    d = 'x; resp = 2'bxx; got = 0;
    araddr = a; arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin tick(); got = 1; break; end
      tick();
    end
    arvalid = 0;
    if (!got) begin timeout("ar"); return; end
    got = 0; rready = 1;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin d = rdata; resp = rresp; got = 1; tick(); break; end
      tick();
    end
    rready = 0;
    if (!got) timeout("r");
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) tick();
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid, core_start} !== 6'b0 || rdata !== 32'h0 ||
        bresp !== 2'b0 || rresp !== 2'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdy/vld=%b rdata=%h, need 0", {awready, wready, arready, bvalid, rvalid, core_start}, rdata);
    end
    rst_n = 1;
    tick();
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++; $display("FAIL ready_after_reset: %b, need 111", {awready, wready, arready});
    end
  endtask

  task automatic test_seq_rw();
    logic [1:0] r; logic [31:0] d; int s0;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i*4), 32'(i+1), 4'hF, r);
      vectors++;
      if (r !== 2'b00) begin errors++; $display("FAIL seq_bresp[%0d]: %b, need 00", i, r); end
    end
    repeat (2) tick();
    vectors++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL seq_start_pulses: %0d, need 1", start_cnt - s0); end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), d, r);
      vectors++;
      if (d !== 32'(i+1) || r !== 2'b00) begin
        errors++; $display("FAIL seq_read[%0d]: data=%h resp=%b, need %h 00", i, d, r, i+1);
      end
    end
    vectors++;
    if (core_operand !== 32'h2) begin errors++; $display("FAIL operand: %h, need 2", core_operand); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r; logic [31:0] d;
    axi_write(5'h08, 32'h0, 4'hF, r);
    wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1;
    tick(); wvalid = 0;
    tick(); tick();
    awaddr = 5'h08; awvalid = 1;
    vectors++;
    if (awready !== 1'b1) begin errors++; $display("FAIL wfirst_awready: %b, need 1", awready); end
    tick(); awvalid = 0;
    vectors++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL wfirst_bvalid_early: %b, need 0", bvalid); end
    tick();
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++; $display("FAIL wfirst_bvalid: %b resp=%b, need 1 00", bvalid, bresp);
    end
    bready = 1; tick(); bready = 0;
    axi_read(5'h08, d, r);
    vectors++;
    if (d !== 32'h00A500A5) begin errors++; $display("FAIL wstrb_merge: %h, need 00a500a5", d); end
  endtask

  task automatic test_bready_stall();
    logic [1:0] r; logic [31:0] d; int bad;
    bad = 0;
    awaddr = 5'h0C; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    tick(); awvalid = 0; wvalid = 0;
    tick();
    awaddr = 5'h0C; wdata = 32'h22222222; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad++;
      tick();
    end
    awvalid = 0; wvalid = 0;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL b_stall: %0d bad cycles, need 0", bad); end
    axi_read(5'h0C, d, r);
    vectors++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL stall_no_accept: %h, need 11111111", d); end
    bready = 1; tick(); bready = 0;
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      errors++; $display("FAIL b_release: bvalid=%b awready=%b, need 0 1", bvalid, awready);
    end
    axi_write(5'h0C, 32'h22222222, 4'hF, r);
    axi_read(5'h0C, d, r);
    vectors++;
    if (d !== 32'h22222222) begin errors++; $display("FAIL after_stall_write: %h, need 22222222", d); end
  endtask

  task automatic test_core();
    logic [1:0] r; logic [31:0] d; int s0;
    axi_write(5'h04, 32'h00010000, 4'hF, r);
    vectors++;
    if (core_operand !== 32'h00010000) begin errors++; $display("FAIL core_operand: %h, need 00010000", core_operand); end
    s0 = start_cnt;
    axi_write(5'h00, 32'h1, 4'hF, r);
    tick();
    vectors++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL core_start: %0d pulses, need 1", start_cnt - s0); end
    core_busy = 1;
    axi_read(5'h14, d, r);
    vectors++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_busy: %h, need 1", d); end
    core_busy = 0; core_done = 1; core_result = 32'h0000FFFF;
    tick();
    core_done = 0; core_result = 32'h0;
    axi_read(5'h14, d, r);
    vectors++;
    if (d !== 32'h2) begin errors++; $display("FAIL status_done: %h, need 2", d); end
    axi_read(5'h14, d, r);
    vectors++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_cleared: %h, need 0", d); end
    axi_read(5'h10, d, r);
    vectors++;
    if (d !== 32'h0000FFFF) begin errors++; $display("FAIL result: %h, need 0000ffff", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] r; logic [31:0] d; int bad;
    bad = 0;
    araddr = 5'h08; arvalid = 1; rready = 0;
    tick(); arvalid = 0;
    vectors++;
    if (rvalid !== 1'b1 || rdata !== 32'h00A500A5) begin
      errors++; $display("FAIL pre_reset_r: rvalid=%b rdata=%h, need 1 00a500a5", rvalid, rdata);
    end
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid, core_start} !== 6'b0 || rdata !== 32'h0 || rresp !== 2'b0) begin
      errors++; $display("FAIL async_reset: rdy/vld=%b rdata=%h, need 0", {awready, wready, arready, bvalid, rvalid, core_start}, rdata);
    end
    tick(); rst_n = 1; rready = 1;
    for (int i = 0; i < 5; i++) begin
      if (rvalid !== 1'b0) bad++;
      tick();
    end
    rready = 0;
    vectors++;
    if (bad != 0) begin errors++; $display("FAIL stale_r_beat: %0d cycles, need 0", bad); end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i*4), d, r);
      vectors++;
      if (d !== 32'h0) begin errors++; $display("FAIL reg_after_reset[%0d]: %h, need 0", i, d); end
    end
  endtask

  task automatic test_slverr();
    logic [1:0] r, exp_resp; logic [31:0] d;
`ifdef FIXED_FISR_SLVERR_EN
    exp_resp = 2'b10;
`else
    exp_resp = 2'b00;
`endif
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, r);
    vectors++;
    if (r !== exp_resp) begin errors++; $display("FAIL ro_write_bresp: %b, need %b", r, exp_resp); end
    axi_read(5'h1C, d, r);
    vectors++;
    if (r !== exp_resp || d !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: resp=%b data=%h, need %b 0", r, d, exp_resp);
    end
    axi_read(5'h10, d, r);
    vectors++;
    if (d !== 32'h0 || r !== 2'b00) begin errors++; $display("FAIL result_unchanged: %h resp=%b, need 0 00", d, r); end
  endtask

  initial begin
    test_reset();
    test_seq_rw();
    test_w_before_aw();
    test_bready_stall();
    test_core();
    test_reset_mid_read();
    test_slverr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
